lzrw1_compressor: RTL and testbench
===================================

Name: lzrw1_compressor

Overview:
- LZRW1-style compressor, the transmit-side counterpart of the team's decompressor.
- Accepts a byte stream and emits 16-bit tokens with a 1-bit control word, in exactly the format the decompressor consumes.
- Literal token: control 0, data {8'h00, byte}.
- Copy token: control 1, data {length[3:0], offset[11:0]}. It means: output `length` bytes, byte k taken from (current output position − offset + k).

Parameters:
HISTORY_SIZE, 4096, circular history depth in bytes; offset range 1..HISTORY_SIZE-1.
HASH_BITS, 8, hash table index width (2^HASH_BITS entries).
MAX_LEN, 15, maximum copy length and lookahead depth.
MIN_LEN, 3, minimum copy length worth encoding.

Ports:
clock  in  1  clock.
reset  in  1  reset, asynchronous, active-high.
in_byte  in  8  uncompressed input byte.
in_valid  in  1  in_byte valid.
in_last  in  1  qualifies in_byte as the final byte of the stream.
in_ready  out  1  byte accepted when in_valid && in_ready.
data_out  out  16  token (literal or {length, offset}).
control_word_out  out  1  0 = literal, 1 = copy.
out_valid  out  1  token valid; held with data stable until out_ready.
out_ready  in  1  sink accepts token (tie to !decompressor_busy).
out_last  out  1  qualifies the final token of a stream.

Behaviour:
- Reset (async):
  - State FILL; lookahead LA empty (cnt=0); pos=0; last_seen=0.
  - All hash table valid bits cleared.
  - Outputs: in_ready=0 for the reset cycle, then 1. out_valid=0, out_last=0, data_out=0, control_word_out=0.
  - Reset mid-token discards all state; no partial token is emitted.
- Storage:
  - LA: MAX_LEN-byte shift register.
  - History: HISTORY_SIZE x 8 RAM, synchronous read, 1-cycle latency, written at pos.
  - Hash table: 2^HASH_BITS entries of {valid, 12-bit position}.
- Hash: h = (({LA0,4'b0}) ^ ({2'b0,LA1,2'b0}) ^ ({4'b0,LA2}))[HASH_BITS-1:0], computed with 12-bit intermediates.
- States:
  - FILL:
    - in_ready = (cnt<MAX_LEN) && !last_seen.
    - Each accepted byte appends to LA at index cnt; in_last sets last_seen.
    - If cnt==MAX_LEN, or (last_seen && cnt>0): go HASH if cnt>=MIN_LEN, else go EMIT as a literal.
    - If last_seen && cnt==0: clear last_seen and stay in FILL (stream ended).
  - HASH (1 cycle):
    - Read table[h] into cand/cvalid, then write table[h] = {1, pos}, always.
    - off = (pos − cand) mod HISTORY_SIZE.
    - If cvalid && off!=0: go MATCH, else go EMIT as a literal.
  - MATCH:
    - Read history[cand+i] for i=0,1,…; compare to LA[i] one cycle later.
    - len = count of leading equal bytes.
    - Stop at the first mismatch, at i==cnt, at i==MAX_LEN, or at i==off (no overlap into unwritten bytes).
    - At most MAX_LEN+1 cycles.
    - If len>=MIN_LEN, EMIT a copy {len, off}; else EMIT a literal LA[0].
  - EMIT:
    - out_valid=1; token held stable until out_valid && out_ready.
    - out_last=1 iff last_seen && the bytes consumed by this token == cnt.
    - Then go SHIFT with n = len (copy) or 1 (literal).
  - SHIFT (n cycles):
    - Each cycle: write LA[0] to history[pos], pos=pos+1 mod HISTORY_SIZE, shift LA down by one, cnt−1.
    - Then go FILL.
- Positions skipped inside a copy do not update the hash table.
- Hash table and history persist across streams; only reset clears them.
- Stale or aliased table entries are harmless: MATCH verifies bytes, and history at pos−off always holds the byte from that distance.
- A hash collision with mismatching bytes yields a literal.
- Simultaneous: in_ready is 0 outside FILL, so no input is taken during HASH/MATCH/EMIT/SHIFT. out_ready is ignored when out_valid=0.
- Lengths 0..2 are never encoded; offset 0 is never emitted.

Test Plan:
1. "ABC" + in_last on C -> tokens 0x0041/c0, 0x0042/c0, 0x0043/c0; out_last only on the third.
2. "ABCDEFABCDEF" + last -> six literals 0x0041..0x0046, then 0x6006/c1 with out_last.
3. 16 distinct bytes 0x10..0x1F repeated twice (32 bytes) -> 16 literals, then 0xF010/c1, then literal 0x001F/c0 with out_last.
4. Backpressure: hold out_ready=0 for 5 cycles during a copy token -> out_valid stays 1, data_out constant, in_ready=0, no extra token; release -> exactly one handshake.
5. Hash collision: "ABC" then a 3-byte sequence with the same hash but different bytes -> all literals, no copy token.
6. Reset asserted during MATCH -> outputs go to reset values immediately. Replaying "ABCABC" then produces 3 literals + 0x3003/c1, proving the table was cleared.

Source files
------------

// File: rtl/lzrw1_compressor_if.sv
// Byte-stream input and token-stream output of the LZRW1 compressor.
// master: the environment (byte source and token sink); slave: the compressor.
interface lzrw1_compressor_if;
   logic [7:0]  in_byte;
   logic        in_valid;
   logic        in_last;
   logic        in_ready;
   logic [15:0] data_out;
   logic        control_word_out;
   logic        out_valid;
   logic        out_ready;
   logic        out_last;

   modport master (
      output in_byte, in_valid, in_last, out_ready,
      input  in_ready, data_out, control_word_out, out_valid, out_last
   );

   modport slave (
      input  in_byte, in_valid, in_last, out_ready,
      output in_ready, data_out, control_word_out, out_valid, out_last
   );
endinterface

// File: rtl/lzrw1_compressor.sv
// LZRW1-style compressor: gathers a lookahead window, hashes its first three
// bytes into a position table, verifies candidates against the history RAM and
// emits either a literal token or a {length, offset} copy token.
module lzrw1_compressor #(
   parameter int unsigned HISTORY_SIZE = 4096,
   parameter int unsigned HASH_BITS    = 8,
   parameter int unsigned MAX_LEN      = 15,
   parameter int unsigned MIN_LEN      = 3
) (
   input logic               clock,
   input logic               reset,
   lzrw1_compressor_if.slave bus
);

   localparam int unsigned PosW    = $clog2(HISTORY_SIZE);
   localparam int unsigned CntW    = $clog2(MAX_LEN + 1);
   localparam int unsigned Entries = 1 << HASH_BITS;
   localparam logic [CntW-1:0] MaxLenC = CntW'(MAX_LEN);
   localparam logic [CntW-1:0] MinLenC = CntW'(MIN_LEN);
   localparam logic [CntW-1:0] OneC    = CntW'(1);

   typedef enum logic [2:0] {StFill, StHash, StMatch, StEmit, StShift} state_t;

   state_t          state_q;
   logic [7:0]      la_q [MAX_LEN];
   logic [CntW-1:0] cnt_q, len_q, shift_n_q;
   logic [PosW-1:0] pos_q, cand_q, off_q;
   logic            last_seen_q, ready_en_q;
   logic [15:0]     data_out_q;
   logic            control_q, out_valid_q, out_last_q;

   logic [Entries-1:0] tbl_valid_q;
   logic [PosW-1:0]    tbl_pos_q [Entries];
   logic [7:0]         hist_q [HISTORY_SIZE];
   logic [7:0]         hist_rdata_q;

   logic [HASH_BITS-1:0] hash;
   logic [PosW-1:0]      cand_rd, off_calc, hist_raddr;
   logic                 match_stop, accept;

   assign hash     = HASH_BITS'({la_q[0], 4'b0} ^ {2'b0, la_q[1], 2'b0} ^ {4'b0, la_q[2]});
   assign cand_rd  = tbl_pos_q[hash];
   assign off_calc = pos_q - cand_rd;

   assign bus.in_ready = ready_en_q && (state_q == StFill) && (cnt_q < MaxLenC) && !last_seen_q;
   assign accept       = bus.in_valid && bus.in_ready;

   assign bus.data_out         = data_out_q;
   assign bus.control_word_out = control_q;
   assign bus.out_valid        = out_valid_q;
   assign bus.out_last         = out_last_q;

   // History read address: HASH primes byte 0 of the candidate, MATCH runs one ahead.
   always_comb begin
      hist_raddr = cand_q + PosW'(len_q) + PosW'(1);
      if (state_q == StHash) begin
         hist_raddr = cand_rd;
      end
   end

   // Match ends on window exhaustion, length cap, reaching unwritten bytes, or mismatch.
   always_comb begin
      match_stop = (len_q == cnt_q) || (len_q == MaxLenC) || (PosW'(len_q) == off_q) ||
                   (hist_rdata_q != la_q[len_q]);
   end

   // History RAM: written while shifting, synchronous read with one cycle latency.
   always_ff @(posedge clock) begin
      if (state_q == StShift) begin
         hist_q[pos_q] <= la_q[0];
      end
      hist_rdata_q <= hist_q[hist_raddr];
   end

   // Hash table positions; validity lives in the reset domain below.
   always_ff @(posedge clock) begin
      if (state_q == StHash) begin
         tbl_pos_q[hash] <= pos_q;
      end
   end

   // Main FSM with registered token outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= StFill;
         cnt_q       <= '0;
         len_q       <= '0;
         shift_n_q   <= '0;
         pos_q       <= '0;
         cand_q      <= '0;
         off_q       <= '0;
         last_seen_q <= 1'b0;
         ready_en_q  <= 1'b0;
         tbl_valid_q <= '0;
         data_out_q  <= '0;
         control_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         for (int i = 0; i < int'(MAX_LEN); i++) begin
            la_q[i] <= '0;
         end
      end else begin
         ready_en_q <= 1'b1;
         case (state_q)
            StFill: begin
               if (accept) begin
                  la_q[cnt_q] <= bus.in_byte;
                  cnt_q       <= cnt_q + OneC;
                  if (bus.in_last) begin
                     last_seen_q <= 1'b1;
                  end
               end
               if ((cnt_q == MaxLenC) || (last_seen_q && (cnt_q != '0))) begin
                  if (cnt_q >= MinLenC) begin
                     state_q <= StHash;
                  end else begin
                     data_out_q  <= {8'h00, la_q[0]};
                     control_q   <= 1'b0;
                     out_valid_q <= 1'b1;
                     out_last_q  <= last_seen_q && (cnt_q == OneC);
                     shift_n_q   <= OneC;
                     state_q     <= StEmit;
                  end
               end else if (last_seen_q && (cnt_q == '0)) begin
                  last_seen_q <= 1'b0;
               end
            end
            StHash: begin
               tbl_valid_q[hash] <= 1'b1;
               cand_q            <= cand_rd;
               off_q             <= off_calc;
               len_q             <= '0;
               if (tbl_valid_q[hash] && (off_calc != '0)) begin
                  state_q <= StMatch;
               end else begin
                  data_out_q  <= {8'h00, la_q[0]};
                  control_q   <= 1'b0;
                  out_valid_q <= 1'b1;
                  out_last_q  <= last_seen_q && (cnt_q == OneC);
                  shift_n_q   <= OneC;
                  state_q     <= StEmit;
               end
            end
            StMatch: begin
               if (!match_stop) begin
                  len_q <= len_q + OneC;
               end else if (len_q >= MinLenC) begin
                  data_out_q  <= {len_q, off_q};
                  control_q   <= 1'b1;
                  out_valid_q <= 1'b1;
                  out_last_q  <= last_seen_q && (len_q == cnt_q);
                  shift_n_q   <= len_q;
                  state_q     <= StEmit;
               end else begin
                  data_out_q  <= {8'h00, la_q[0]};
                  control_q   <= 1'b0;
                  out_valid_q <= 1'b1;
                  out_last_q  <= last_seen_q && (cnt_q == OneC);
                  shift_n_q   <= OneC;
                  state_q     <= StEmit;
               end
            end
            StEmit: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  out_last_q  <= 1'b0;
                  state_q     <= StShift;
               end
            end
            StShift: begin
               for (int i = 0; i < int'(MAX_LEN) - 1; i++) begin
                  la_q[i] <= la_q[i+1];
               end
               pos_q     <= pos_q + PosW'(1);
               cnt_q     <= cnt_q - OneC;
               shift_n_q <= shift_n_q - OneC;
               if (shift_n_q == OneC) begin
                  state_q <= StFill;
               end
            end
            default: state_q <= StFill;
         endcase
      end
   end

endmodule

// File: tb/tb_lzrw1_compressor.sv
// Directed bench for lzrw1_compressor: byte streams in, expected token lists out.
module tb_lzrw1_compressor;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   lzrw1_compressor_if bus ();

   lzrw1_compressor dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0]  tx_q [$];
   logic [17:0] exp_q [$];  // {last, control, data}

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic push_lit(input logic [7:0] b, input logic last);
      exp_q.push_back({last, 1'b0, 8'h00, b});
   endtask

   task automatic push_copy(input logic [3:0] len, input logic [11:0] off, input logic last);
      exp_q.push_back({last, 1'b1, len, off});
   endtask

   task automatic push_str(input string s);
      for (int i = 0; i < s.len(); i++) begin
         tx_q.push_back(s[i]);
      end
   endtask

   task automatic apply_reset();
      @(negedge clock);
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
   endtask

   // Starts and ends on a falling edge.
   task automatic send_bytes(input bit with_last);
      int n;
      int w;
      n = tx_q.size();
      for (int i = 0; i < n; i++) begin
         bus.in_byte  = tx_q[i];
         bus.in_valid = 1'b1;
         bus.in_last  = with_last && (i == n - 1);
         w = 0;
         while (!bus.in_ready && w < 400) begin
            @(negedge clock);
            w++;
         end
         if (!bus.in_ready) begin
            check_eq($sformatf("send timeout byte%0d", i), 32'd0, 32'd1);
            break;
         end
         @(posedge clock);
         @(negedge clock);
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      tx_q.delete();
   endtask

   // Starts and ends on a falling edge; stalls copy tokens for 'stall' cycles.
   task automatic recv_tokens(input int stall);
      logic [17:0] e;
      int w;
      int k;
      k = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         w = 0;
         while (!bus.out_valid && w < 400) begin
            @(negedge clock);
            w++;
         end
         if (!bus.out_valid) begin
            check_eq($sformatf("tok%0d timeout", k), 32'd0, 32'd1);
            exp_q.delete();
            break;
         end
         if (stall > 0 && e[16]) begin
            for (int s = 0; s < stall; s++) begin
               @(negedge clock);
               check_eq($sformatf("tok%0d stall valid", k), 32'(bus.out_valid), 32'd1);
               check_eq($sformatf("tok%0d stall data", k), 32'(bus.data_out), 32'(e[15:0]));
               check_eq($sformatf("tok%0d stall in_ready", k), 32'(bus.in_ready), 32'd0);
            end
         end
         check_eq($sformatf("tok%0d data", k), 32'(bus.data_out), 32'(e[15:0]));
         check_eq($sformatf("tok%0d control", k), 32'(bus.control_word_out), 32'(e[16]));
         check_eq($sformatf("tok%0d last", k), 32'(bus.out_last), 32'(e[17]));
         bus.out_ready = 1'b1;
         @(posedge clock);
         #1;
         bus.out_ready = 1'b0;
         check_eq($sformatf("tok%0d single handshake", k), 32'(bus.out_valid), 32'd0);
         @(negedge clock);
         k++;
      end
   endtask

   task automatic run_stream(input bit with_last, input int stall);
      fork
         send_bytes(with_last);
         recv_tokens(stall);
      join
   endtask

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, " in_ready"}, 32'(bus.in_ready), 32'd0);
      check_eq({tag, " out_valid"}, 32'(bus.out_valid), 32'd0);
      check_eq({tag, " out_last"}, 32'(bus.out_last), 32'd0);
      check_eq({tag, " data_out"}, 32'(bus.data_out), 32'd0);
      check_eq({tag, " control"}, 32'(bus.control_word_out), 32'd0);
   endtask

   initial begin
      bus.in_byte   = 8'h00;
      bus.in_valid  = 1'b0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b0;

      // Reset values, then in_ready rises once reset is released.
      #1 reset = 1'b1;
      #2 check_idle_outputs("reset");
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check_eq("in_ready after reset", 32'(bus.in_ready), 32'd1);

      // Short stream: three literals, last flag on the third only.
      push_str("ABC");
      push_lit(8'h41, 1'b0);
      push_lit(8'h42, 1'b0);
      push_lit(8'h43, 1'b1);
      run_stream(1'b1, 0);

      // Repeat at distance 6 becomes one copy token.
      apply_reset();
      push_str("ABCDEFABCDEF");
      for (int i = 0; i < 6; i++) begin
         push_lit(8'h41 + 8'(i), 1'b0);
      end
      push_copy(4'd6, 12'd6, 1'b1);
      run_stream(1'b1, 0);

      // Full-length copy capped by the lookahead, then a trailing literal.
      apply_reset();
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 16; i++) begin
            tx_q.push_back(8'h10 + 8'(i));
         end
      end
      for (int i = 0; i < 16; i++) begin
         push_lit(8'h10 + 8'(i), 1'b0);
      end
      push_copy(4'd15, 12'd16, 1'b0);
      push_lit(8'h1f, 1'b1);
      run_stream(1'b1, 0);

      // Backpressure on the copy token.
      apply_reset();
      push_str("ABCABC");
      push_lit(8'h41, 1'b0);
      push_lit(8'h42, 1'b0);
      push_lit(8'h43, 1'b0);
      push_copy(4'd3, 12'd3, 1'b1);
      run_stream(1'b1, 5);
      repeat (6) @(negedge clock);
      check_eq("post stream out_valid", 32'(bus.out_valid), 32'd0);
      check_eq("post stream in_ready", 32'(bus.in_ready), 32'd1);

      // Hash collision: "QBC" hashes like "ABC" but the bytes differ.
      apply_reset();
      push_str("ABCQBC");
      push_lit(8'h41, 1'b0);
      push_lit(8'h42, 1'b0);
      push_lit(8'h43, 1'b0);
      push_lit(8'h51, 1'b0);
      push_lit(8'h42, 1'b0);
      push_lit(8'h43, 1'b1);
      run_stream(1'b1, 0);

      // Reset during a long match, then replay on a cleared table.
      apply_reset();
      for (int i = 0; i < 31; i++) begin
         tx_q.push_back(8'h10 + 8'(i % 16));
      end
      for (int i = 0; i < 16; i++) begin
         push_lit(8'h10 + 8'(i), 1'b0);
      end
      run_stream(1'b0, 0);
      repeat (2) @(negedge clock);
      check_eq("pre-reset data_out", 32'(bus.data_out), 32'h001f);
      reset = 1'b1;
      #1 check_idle_outputs("mid-match reset");
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      push_str("ABCABC");
      push_lit(8'h41, 1'b0);
      push_lit(8'h42, 1'b0);
      push_lit(8'h43, 1'b0);
      push_copy(4'd3, 12'd3, 1'b1);
      run_stream(1'b1, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
